action_sequencer: RTL and testbench



---
 rtl/action_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_action_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/action_sequencer.sv
// Purpose : per-fighter attack / dodge / shield / hit-stun sequencer, timed in game frames.
// Latency : 1 clock from the deciding frame_tick or hit_in to new state and flags.
// Backpressure: none; frame_tick and hit_in are strobes and are always accepted.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   frame_tick                one-cycle strobe per game frame
//   grounded                  fighter standing on ground
//   btn_atk/down/left/right   debounced level buttons, edge-detected on frame ticks
//   hit_in, hitstun_frames    strike pulse and requested stun length (0 means 1)
//   *_active, hitbox_en,      state flags and collision controls
//   invuln, action_state,
//   shield_hp
module action_sequencer #(
    parameter int unsigned ATK_STARTUP    = 4,
    parameter int unsigned ATK_ACTIVE     = 3,
    parameter int unsigned ATK_RECOVERY   = 8,
    parameter int unsigned DODGE_FRAMES   = 12,
    parameter int unsigned DODGE_INVULN   = 8,
    parameter int unsigned SHIELD_MAX     = 120,
    parameter int unsigned SHIELD_HIT_DMG = 16,
    parameter int unsigned BREAK_STUN     = 90
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       grounded,
    input  logic       btn_atk,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       hit_in,
    input  logic [7:0] hitstun_frames,
    output logic       hit_stun_active,
    output logic       attack_active,
    output logic       dodge_active,
    output logic       shield_active,
    output logic       hitbox_en,
    output logic       invuln,
    output logic [2:0] action_state,
    output logic [7:0] shield_hp
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATK_SU  = 3'd1,
        S_ATK_ACT = 3'd2,
        S_ATK_REC = 3'd3,
        S_DODGE   = 3'd4,
        S_SHIELD  = 3'd5,
        S_HITSTUN = 3'd6
    } state_t;

    localparam logic [7:0] L_ATK_SU   = 8'(ATK_STARTUP);
    localparam logic [7:0] L_ATK_ACT  = 8'(ATK_ACTIVE);
    localparam logic [7:0] L_ATK_REC  = 8'(ATK_RECOVERY);
    localparam logic [7:0] L_DODGE    = 8'(DODGE_FRAMES);
    // invulnerable while the remaining count is above this threshold
    localparam logic [7:0] L_VULN_CNT = 8'(DODGE_FRAMES - DODGE_INVULN);
    localparam logic [7:0] L_SH_MAX   = 8'(SHIELD_MAX);
    localparam logic [7:0] L_SH_DMG   = 8'(SHIELD_HIT_DMG);
    localparam logic [7:0] L_BREAK    = 8'(BREAK_STUN);

    state_t     r_state;
    logic [7:0] r_frame_cnt;
    logic [7:0] r_shield_hp;
    logic [3:0] r_prev_btn;   // {right, left, down, atk}
    logic [3:0] r_btn_arm;    // set once a button has been seen released since reset

    state_t     w_state_nxt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] w_hp_nxt;
    logic [3:0] w_btn;
    logic [3:0] w_press;
    logic       w_lr_press;
    logic       w_invuln;
    logic       w_hit;
    logic       w_cnt_last;
    logic [7:0] w_hp_regen;
    logic [7:0] w_hp_hit;
    logic [7:0] w_hp_dec;

    assign w_btn      = {btn_right, btn_left, btn_down, btn_atk};
    // the arm mask keeps a button held through reset from counting as a press
    assign w_press    = w_btn & ~r_prev_btn & r_btn_arm;
    assign w_lr_press = w_press[2] | w_press[3];
    assign w_invuln   = (r_state == S_DODGE) && (r_frame_cnt > L_VULN_CNT);
    assign w_hit      = hit_in & ~w_invuln;
    assign w_cnt_last = (r_frame_cnt <= 8'd1);
    assign w_hp_regen = (r_shield_hp >= L_SH_MAX) ? L_SH_MAX : r_shield_hp + 8'd1;
    assign w_hp_hit   = (r_shield_hp > L_SH_DMG) ? r_shield_hp - L_SH_DMG : 8'd0;
    // shield is only ever occupied with hp >= 1, so this cannot wrap
    assign w_hp_dec   = r_shield_hp - 8'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_frame_cnt;
        w_hp_nxt    = r_shield_hp;
        if (w_hit) begin
            // a hit pre-empts every frame_tick rule, including regen and count-down
            if (r_state == S_SHIELD) begin
                w_hp_nxt = w_hp_hit;
                if (w_hp_hit == 8'd0) begin
                    w_state_nxt = S_HITSTUN;
                    w_cnt_nxt   = L_BREAK;
                end
            end else begin
                w_state_nxt = S_HITSTUN;
                w_cnt_nxt   = (hitstun_frames == 8'd0) ? 8'd1 : hitstun_frames;
            end
        end else if (frame_tick) begin
            if (r_state != S_SHIELD) begin
                w_hp_nxt = w_hp_regen;
            end
            if (r_state != S_IDLE && r_state != S_SHIELD && !w_cnt_last) begin
                w_cnt_nxt = r_frame_cnt - 8'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_press[0]) begin
                        w_state_nxt = S_ATK_SU;
                        w_cnt_nxt   = L_ATK_SU;
                    end else if (grounded && btn_down && w_lr_press) begin
                        w_state_nxt = S_DODGE;
                        w_cnt_nxt   = L_DODGE;
                    end else if (grounded && btn_down && r_shield_hp != 8'd0) begin
                        w_state_nxt = S_SHIELD;
                        w_cnt_nxt   = 8'd0;
                    end
                end
                S_ATK_SU: begin
                    if (w_cnt_last) begin
                        w_state_nxt = S_ATK_ACT;
                        w_cnt_nxt   = L_ATK_ACT;
                    end
                end
                S_ATK_ACT: begin
                    if (w_cnt_last) begin
                        w_state_nxt = S_ATK_REC;
                        w_cnt_nxt   = L_ATK_REC;
                    end
                end
                S_ATK_REC, S_DODGE, S_HITSTUN: begin
                    if (w_cnt_last) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 8'd0;
                    end
                end
                S_SHIELD: begin
                    w_hp_nxt = w_hp_dec;
                    if (w_hp_dec == 8'd0) begin
                        w_state_nxt = S_HITSTUN;
                        w_cnt_nxt   = L_BREAK;
                    end else if (w_lr_press) begin
                        w_state_nxt = S_DODGE;
                        w_cnt_nxt   = L_DODGE;
                    end else if (!btn_down || !grounded) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_frame_cnt <= 8'd0;
            r_shield_hp <= L_SH_MAX;
            r_prev_btn  <= 4'd0;
            r_btn_arm   <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_cnt_nxt;
            r_shield_hp <= w_hp_nxt;
            if (frame_tick) begin
                r_prev_btn <= w_btn;
                r_btn_arm  <= r_btn_arm | ~w_btn;
            end
        end
    end

    assign action_state    = r_state;
    assign hit_stun_active = (r_state == S_HITSTUN);
    assign attack_active   = (r_state == S_ATK_SU) || (r_state == S_ATK_ACT) || (r_state == S_ATK_REC);
    assign dodge_active    = (r_state == S_DODGE);
    assign shield_active   = (r_state == S_SHIELD);
    assign hitbox_en       = (r_state == S_ATK_ACT);
    assign invuln          = w_invuln;
    assign shield_hp       = r_shield_hp;

endmodule

// File: tb/tb_action_sequencer.sv
// Purpose : randomized + directed bench for action_sequencer against a frame-level model.
// Latency : model advances once per applied cycle; outputs compared on the falling edge.
// Backpressure: n/a.
module tb_action_sequencer;

    localparam int SU = 4, ACTF = 3, REC = 8, DF = 12, DI = 8;
    localparam int SH_MAX = 120, SH_DMG = 16, BRK = 90;
    localparam int ATK_TOTAL = SU + ACTF + REC;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick, grounded, btn_atk, btn_down, btn_left, btn_right, hit_in;
    logic [7:0] hitstun_frames;
    logic       hit_stun_active, attack_active, dodge_active, shield_active, hitbox_en, invuln;
    logic [2:0] action_state;
    logic [7:0] shield_hp;

    action_sequencer dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .grounded(grounded),
        .btn_atk(btn_atk), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .hit_in(hit_in), .hitstun_frames(hitstun_frames),
        .hit_stun_active(hit_stun_active), .attack_active(attack_active),
        .dodge_active(dodge_active), .shield_active(shield_active),
        .hitbox_en(hitbox_en), .invuln(invuln), .action_state(action_state), .shield_hp(shield_hp)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: which action is running and how far it has progressed, in frames.
    // 0 none, 1 attack, 2 dodge, 3 shield, 4 stun
    int       m_act, m_el, m_left, m_hp;
    bit [3:0] m_prev, m_arm;   // {right,left,down,atk}

    task automatic model_reset();
        m_act = 0; m_el = 0; m_left = 0; m_hp = SH_MAX; m_prev = 0; m_arm = 0;
    endtask

    function automatic int exp_state();
        if (m_act == 1) return (m_el < SU) ? 1 : (m_el < SU + ACTF) ? 2 : 3;
        if (m_act == 2) return 4;
        if (m_act == 3) return 5;
        if (m_act == 4) return 6;
        return 0;
    endfunction

    function automatic bit exp_inv();
        return (m_act == 2) && (m_el < DI);
    endfunction

    task automatic model_step(input bit tick, input bit g, input bit [3:0] btn,
                              input bit hit, input int hf);
        bit [3:0] pr;
        bit       h;
        pr = btn & ~m_prev & m_arm;
        h  = hit && !exp_inv();
        if (tick) begin
            m_prev = btn;
            m_arm  = m_arm | ~btn;
        end
        if (h) begin
            if (m_act == 3) begin
                m_hp = (m_hp > SH_DMG) ? m_hp - SH_DMG : 0;
                if (m_hp == 0) begin m_act = 4; m_left = BRK; end
            end else begin
                m_act = 4; m_left = (hf == 0) ? 1 : hf;
            end
        end else if (tick) begin
            if (m_act != 3 && m_hp < SH_MAX) m_hp++;
            case (m_act)
                0: begin
                    if (pr[0]) begin m_act = 1; m_el = 0; end
                    else if (g && btn[1] && (pr[2] || pr[3])) begin m_act = 2; m_el = 0; end
                    else if (g && btn[1] && m_hp > 0) m_act = 3;
                end
                1: begin m_el++; if (m_el == ATK_TOTAL) m_act = 0; end
                2: begin m_el++; if (m_el == DF) m_act = 0; end
                4: begin m_left--; if (m_left == 0) m_act = 0; end
                3: begin
                    m_hp--;
                    if (m_hp == 0) begin m_act = 4; m_left = BRK; end
                    else if (pr[2] || pr[3]) begin m_act = 2; m_el = 0; end
                    else if (!btn[1] || !g) m_act = 0;
                end
                default: m_act = 0;
            endcase
        end
    endtask

    task automatic check_outputs();
        int e;
        e = exp_state();
        chk("action_state", int'(action_state), e);
        chk("flags", int'({hit_stun_active, attack_active, dodge_active, shield_active, hitbox_en, invuln}),
            int'({e == 6, e >= 1 && e <= 3, e == 4, e == 5, e == 2, exp_inv()}));
        chk("shield_hp", int'(shield_hp), m_hp);
    endtask

    // called at a falling edge: drive, advance model, then compare at the next falling edge
    task automatic apply(input bit tick, input bit g, input bit [3:0] btn,
                         input bit hit, input int hf);
        frame_tick = tick; grounded = g;
        {btn_right, btn_left, btn_down, btn_atk} = btn;
        hit_in = hit; hitstun_frames = 8'(hf);
        model_step(tick, g, btn, hit, hf);
        @(negedge clk);
        check_outputs();
    endtask

    bit [3:0] cur_b;
    bit       cur_g;

    task automatic run_random(input int cycles, input int tick_div, input bit shield_mode, input int hit_div);
        for (int i = 0; i < cycles; i++) begin
            if (shield_mode) begin
                cur_b = 4'b0010; cur_g = 1'b1;
            end else begin
                if ($urandom_range(0, 5) == 0) cur_b[$urandom_range(0, 3)] ^= 1'b1;
                if ($urandom_range(0, 60) == 0) cur_g = ~cur_g;
            end
            apply($urandom_range(0, tick_div - 1) == 0, cur_g, cur_b,
                  $urandom_range(0, hit_div - 1) == 0, int'($urandom_range(0, 40)));
        end
    endtask

    task automatic goto_idle(input string tag);
        for (int i = 0; i < 400 && m_act != 0; i++) apply(1, 1, 4'b0000, 0, 0);
        chk(tag, int'(action_state), 0);
    endtask

    task automatic do_reset(input bit [3:0] held);
        {btn_right, btn_left, btn_down, btn_atk} = held;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_state", int'(action_state), 0);
        chk("rst_flags", int'({hit_stun_active, attack_active, dodge_active, shield_active, hitbox_en, invuln}), 0);
        chk("rst_hp", int'(shield_hp), SH_MAX);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; frame_tick = 0; grounded = 1; hit_in = 0; hitstun_frames = 0;
        {btn_right, btn_left, btn_down, btn_atk} = 4'b0000;
        model_reset();
        cur_b = 0; cur_g = 1;
        repeat (2) @(negedge clk);
        check_outputs();
        do_reset(4'b0000);

        // attack: arm, press, hold through the whole chain
        apply(1, 1, 4'b0000, 0, 0);
        apply(1, 1, 4'b0001, 0, 0);
        chk("atk_su", int'(action_state), 1);
        for (int t = 1; t <= ATK_TOTAL; t++) begin
            apply(1, 1, 4'b0001, 0, 0);
            apply(0, 1, 4'b0001, 0, 0);
            if (t == SU) chk("atk_act", int'(hitbox_en), 1);
        end
        chk("atk_done", int'(action_state), 0);
        apply(1, 1, 4'b0001, 0, 0);
        chk("atk_no_retrig", int'(action_state), 0);

        // dodge via shield, hit inside and after the invulnerable window
        goto_idle("idle_before_dodge");
        apply(1, 1, 4'b0010, 0, 0);
        apply(1, 1, 4'b1010, 0, 0);
        chk("dodge_enter", int'(action_state), 4);
        repeat (3) apply(1, 1, 4'b1010, 0, 0);
        apply(0, 1, 4'b1010, 1, 20);
        chk("dodge_invuln_hit", int'(action_state), 4);
        repeat (6) apply(1, 1, 4'b1010, 0, 0);
        apply(0, 1, 4'b1010, 1, 20);
        chk("dodge_late_hit", int'(action_state), 6);

        // hitstun_frames = 0 lasts one tick
        goto_idle("idle_before_zero_stun");
        apply(0, 1, 4'b0000, 1, 0);
        apply(1, 1, 4'b0000, 0, 0);
        chk("zero_stun_one_tick", int'(action_state), 0);

        // hit + tick + attack press in IDLE: stun wins, then reset mid-stun with atk held
        apply(1, 1, 4'b0000, 0, 0);
        apply(1, 1, 4'b0001, 1, 30);
        chk("coinc_hit_stun", int'(action_state), 6);
        repeat (3) apply(1, 1, 4'b0001, 0, 0);
        do_reset(4'b0001);
        repeat (4) apply(1, 1, 4'b0001, 0, 0);
        chk("held_through_rst", int'(action_state), 0);
        apply(1, 1, 4'b0000, 0, 0);
        apply(1, 1, 4'b0001, 0, 0);
        chk("repress_after_rst", int'(action_state), 1);

        // randomized phases: mixed play, long shield holds (drain/break), fast ticks
        run_random(3000, 3, 1'b0, 25);
        run_random(1500, 2, 1'b1, 120);
        run_random(1500, 1, 1'b0, 15);
        do_reset(cur_b);
        run_random(1000, 2, 1'b1, 60);
        run_random(1000, 2, 1'b0, 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
